vec_alu_scheduler: RTL and testbench
====================================

// Module: vec_alu_scheduler
// PURPOSE
//  Shares one combinational vectorial_alu between NUM_REQ requesters (scalar pipe, vector pipe, ...).
//  Round-robin arbitration over valid/ready request channels; two-stage issue/response pipeline.
//  Drives ALU operands from an issue register and captures the result into a response register
//  with a valid/ready handshake. Sits between the decode/issue logic and the shared 128-bit vector ALU.
// PARAMETERS
//  NUM_REQ   2    number of requesters (2..4); requester id width ID_W = $clog2(NUM_REQ), min 1
//  VEC_W     128  operand/result width (4 x 32-bit lanes)
//  LANE_W    32   scalar lane width; scalar ops use bits [LANE_W-1:0]
//  CNT_W     32   width of issued-operation counter
// PORTS
//  clk         in   1              clock, all state updates on rising edge
//  rst         in   1              synchronous reset, active-high
//  req_valid   in   NUM_REQ        per-requester operation valid
//  req_ready   out  NUM_REQ        per-requester accept (one-hot or zero)
//  req_a       in   NUM_REQ*VEC_W  operand A, requester i at [i*VEC_W +: VEC_W]
//  req_b       in   NUM_REQ*VEC_W  operand B
//  req_ctrl    in   NUM_REQ*3      ALUControl code (000 add .. 111 sra)
//  req_vec     in   NUM_REQ        1 = vector (128-bit), 0 = scalar (low lane)
//  alu_a       out  VEC_W          to ALU A
//  alu_b       out  VEC_W          to ALU B
//  alu_ctrl    out  3              to ALU ALUControl
//  alu_vec     out  1              to ALU vectorial
//  alu_result  in   VEC_W          from ALU Result (combinational)
//  alu_zero    in   1              from ALU Zero
//  rsp_valid   out  1              response valid
//  rsp_ready   in   1              response consumer ready
//  rsp_id      out  ID_W           requester id of response
//  rsp_result  out  VEC_W          result
//  rsp_zero    out  1              zero flag
//  op_count    out  CNT_W          number of ops accepted since reset
// BEHAVIOUR
//  - Reset (sync, active-high): S1/S2 empty, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0,
//    req_ready=0, alu_* = 0, op_count=0, RR pointer -> requester 0 highest priority. In-flight ops dropped.
//  - Stages: S1 issue reg {a,b,ctrl,vec,id,valid}; S2 resp reg {result,zero,id,valid}.
//  - s2_adv = S1.valid & (~S2.valid | rsp_ready); s1_free = ~S1.valid | s2_adv.
//  - Grant: when s1_free, round-robin pick among req_valid starting at (last_grant+1) mod NUM_REQ;
//    req_ready[g]=1 only for the winner, combinational, no dependence on req_ready from itself.
//  - Accept (req_valid[g] & req_ready[g]): S1 <= request, last_grant <= g, op_count += 1 (wraps at 2^CNT_W).
//  - Scalar masking: if req_vec=0, bits [VEC_W-1:LANE_W] of a and b loaded into S1 as 0.
//  - alu_* = S1 contents when S1.valid, else all zero.
//  - On s2_adv: S2 <= {alu_result (upper bits forced 0 if scalar), alu_zero, S1.id}, S2.valid=1;
//    if s2_adv and S2 is consumed simultaneously, S2 is overwritten in the same edge (no bubble).
//  - rsp_valid&rsp_ready with no s2_adv: S2.valid <= 0. S2 contents stable while rsp_valid & ~rsp_ready.
//  - Latency: accept at edge N -> rsp_valid at edge N+2 (no stall). Throughput 1 op/cycle.
//  - Full stall: S2 held, S1 held, req_ready all 0; no loss, no duplication, order = accept order.
//  - No requests: pointer unchanged. Single requester always wins when it is the only one valid.
// STRUCTURE
//  - Package vec_alu_pkg: VEC_W/LANE_W constants, ALU control codes ALU_ADD=000, ALU_SUB=001,
//    ALU_AND=010, ALU_OR=011, ALU_XOR=100, ALU_SLL=101, ALU_SRL=110, ALU_SRA=111; issue/resp typedef structs.
//  - Sub-module rr_arbiter (NUM_REQ req in, one-hot grant out, enable, pointer update on accept).
//  - ALU itself instantiated outside; bench connects a vectorial_alu to the alu_* ports.
// TESTING
//  1. req0 scalar add a=0xA b=0x14 ctrl=000 -> rsp_valid 2 cycles after accept, result 0x1E, id 0, zero 0.
//  2. req0,req1 valid every cycle, rsp_ready=1 -> grants 0,1,0,1...; first after reset to 0; op_count +1/cycle.
//  3. 6-op stream, rsp_ready low 3 cycles mid-stream -> req_ready 0 while full, rsp held stable, 6 rsps in order.
//  4. Vector sub {5,6,7,8}-{1,2,3,4} -> 00000004_00000004_00000004_00000004; vector sub A=B -> zero=1.
//  5. Scalar sra a=0xFFFF..._80000000 b=2 -> result 0x00000000_00000000_00000000_E0000000.
//  6. rst asserted with S1,S2 full -> next cycle rsp_valid=0, op_count=0; next grant goes to req0.

Source files
------------

// File: rtl/vec_alu_pkg.sv
// Shared constants, ALU control codes and pipeline stage records for the
// vector ALU scheduler.
package vec_alu_pkg;

  localparam int VEC_W    = 128;
  localparam int LANE_W   = 32;
  localparam int MAX_ID_W = 2;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLL = 3'b101,
    ALU_SRL = 3'b110,
    ALU_SRA = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic                valid;
    logic [MAX_ID_W-1:0] id;
    logic                vec;
    alu_op_e             ctrl;
    logic [VEC_W-1:0]    a;
    logic [VEC_W-1:0]    b;
  } issue_t;

  typedef struct packed {
    logic                valid;
    logic [MAX_ID_W-1:0] id;
    logic                zero;
    logic [VEC_W-1:0]    result;
  } resp_t;

  // Scalar operations only carry the low lane; upper lanes read as zero.
  function automatic logic [VEC_W-1:0] lane_mask(input logic [VEC_W-1:0] d, input logic vec);
    lane_mask = vec ? d : {{(VEC_W-LANE_W){1'b0}}, d[LANE_W-1:0]};
  endfunction

endpackage

// File: rtl/vec_alu_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting one past the last accepted
// requester; the pointer only moves when a grant is actually taken.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               en_i,
  input  logic               accept_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    grant_idx_o
);

  logic [ID_W-1:0] last_q;
  logic [ID_W-1:0] last_d;
  logic [ID_W-1:0] cand;
  logic            found;

  // Search order last+1, last+2, ... wrapping modulo NUM_REQ.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    cand        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(last_q) + k) % NUM_REQ);
      if (en_i && !found && req_i[cand]) begin
        grant_o[cand] = 1'b1;
        grant_idx_o   = cand;
        found         = 1'b1;
      end else begin
        found = found;
      end
    end
    last_d = accept_i ? grant_idx_o : last_q;
  end

  // Reset parks the pointer on the last requester so requester 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= ID_W'(NUM_REQ - 1);
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/vec_alu_scheduler.sv
// Shares one combinational vector ALU between NUM_REQ requesters through a
// two-stage issue/response pipeline with round-robin admission.
module vec_alu_scheduler
  import vec_alu_pkg::*;
#(
  parameter int  NUM_REQ = 2,
  parameter int  CNT_W   = 32,
  localparam int ID_W    = (NUM_REQ > 2) ? 2 : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*VEC_W-1:0] req_a,
  input  logic [NUM_REQ*VEC_W-1:0] req_b,
  input  logic [NUM_REQ*3-1:0]     req_ctrl,
  input  logic [NUM_REQ-1:0]       req_vec,
  output logic [VEC_W-1:0]         alu_a,
  output logic [VEC_W-1:0]         alu_b,
  output logic [2:0]               alu_ctrl,
  output logic                     alu_vec,
  input  logic [VEC_W-1:0]         alu_result,
  input  logic                     alu_zero,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [VEC_W-1:0]         rsp_result,
  output logic                     rsp_zero,
  output logic [CNT_W-1:0]         op_count
);

  issue_t             s1_q, s1_d;
  resp_t              s2_q, s2_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               s2_adv, s1_free, accept;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic [VEC_W-1:0]   sel_a, sel_b;
  logic [2:0]         sel_ctrl;
  logic               sel_vec;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req_valid),
    .en_i        (s1_free & ~rst),
    .accept_i    (accept),
    .grant_o     (grant),
    .grant_idx_o (grant_idx)
  );

  // Pipeline advance conditions and winner operand select.
  always_comb begin
    s2_adv    = s1_q.valid & (~s2_q.valid | rsp_ready);
    s1_free   = ~s1_q.valid | s2_adv;
    accept    = |(req_valid & grant);
    req_ready = grant;
    sel_a     = req_a[int'(grant_idx)*VEC_W +: VEC_W];
    sel_b     = req_b[int'(grant_idx)*VEC_W +: VEC_W];
    sel_ctrl  = req_ctrl[int'(grant_idx)*3 +: 3];
    sel_vec   = req_vec[grant_idx];
  end

  // Next state of the issue stage, response stage and op counter.
  always_comb begin
    s1_d  = s1_q;
    s2_d  = s2_q;
    cnt_d = cnt_q;
    if (accept) begin
      s1_d = '{valid: 1'b1, id: MAX_ID_W'(grant_idx), vec: sel_vec, ctrl: alu_op_e'(sel_ctrl),
               a: lane_mask(sel_a, sel_vec), b: lane_mask(sel_b, sel_vec)};
      cnt_d = cnt_q + CNT_W'(1);
    end else if (s2_adv) begin
      s1_d.valid = 1'b0;
    end else begin
      s1_d = s1_q;
    end
    // A consumed response is overwritten in the same edge when S1 advances.
    if (s2_adv) begin
      s2_d = '{valid: 1'b1, id: s1_q.id, zero: alu_zero, result: lane_mask(alu_result, s1_q.vec)};
    end else if (s2_q.valid && rsp_ready) begin
      s2_d.valid = 1'b0;
    end else begin
      s2_d = s2_q;
    end
  end

  // ALU is driven only while S1 holds an operation.
  always_comb begin
    alu_a    = s1_q.valid ? s1_q.a : '0;
    alu_b    = s1_q.valid ? s1_q.b : '0;
    alu_ctrl = s1_q.valid ? s1_q.ctrl : 3'b000;
    alu_vec  = s1_q.valid ? s1_q.vec : 1'b0;
  end

  // Stage and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q  <= '0;
      s2_q  <= '0;
      cnt_q <= '0;
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      cnt_q <= cnt_d;
    end
  end

  assign rsp_valid  = s2_q.valid;
  assign rsp_id     = ID_W'(s2_q.id);
  assign rsp_result = s2_q.result;
  assign rsp_zero   = s2_q.zero;
  assign op_count   = cnt_q;

endmodule

// File: tb/tb_vec_alu_scheduler.sv
// Bench for vec_alu_scheduler: stand-in lane ALU, directed cases and a random
// stream checked against a queue-based reference of the scheduler behaviour.
module tb_vec_alu_scheduler;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req_valid, req_ready, req_vec;
  logic [255:0] req_a, req_b;
  logic [5:0]   req_ctrl;
  logic [127:0] alu_a, alu_b, alu_result, rsp_result;
  logic [2:0]   alu_ctrl;
  logic         alu_vec, alu_zero, rsp_valid, rsp_ready, rsp_zero;
  logic [0:0]   rsp_id;
  logic [31:0]  op_count;

  always #5 clk = ~clk;

  vec_alu_scheduler #(.NUM_REQ(2), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_ctrl(req_ctrl), .req_vec(req_vec),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_vec(alu_vec),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .op_count(op_count)
  );

  function automatic logic [31:0] lane_op(input logic [2:0] c, input logic [31:0] x, input logic [31:0] y);
    case (c)
      3'd0:    return x + y;
      3'd1:    return x - y;
      3'd2:    return x & y;
      3'd3:    return x | y;
      3'd4:    return x ^ y;
      3'd5:    return x << y[4:0];
      3'd6:    return x >> y[4:0];
      3'd7:    return $unsigned($signed(x) >>> y[4:0]);
      default: return 32'd0;
    endcase
  endfunction

  // Stand-in ALU: scalar mode leaves junk in the upper lanes on purpose.
  always_comb begin
    alu_result = '0;
    for (int l = 0; l < 4; l++) alu_result[l*32 +: 32] = lane_op(alu_ctrl, alu_a[l*32 +: 32], alu_b[l*32 +: 32]);
    if (!alu_vec) alu_result[127:32] = {3{32'hDEADBEEF}};
    alu_zero = alu_vec ? (alu_result == 128'd0) : (alu_result[31:0] == 32'd0);
  end

  typedef struct {
    logic [127:0] res;
    logic         z;
    int           id;
    int           age;
  } item_t;

  item_t        q[$];
  int           last_g, n_rsp, checks, passes, fails;
  logic [31:0]  cnt_m;
  logic [127:0] pa[2], pb[2];
  logic [2:0]   pc[2];
  logic [1:0]   pv, pend;

  function automatic logic [127:0] model_result(input logic [2:0] c, input logic [127:0] a, input logic [127:0] b, input logic v);
    logic [127:0] r;
    r = '0;
    for (int l = 0; l < 4; l++)
      if (v || l == 0) r[l*32 +: 32] = lane_op(c, a[l*32 +: 32], b[l*32 +: 32]);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    req_valid = pend;
    req_a     = {pa[1], pa[0]};
    req_b     = {pb[1], pb[0]};
    req_ctrl  = {pc[1], pc[0]};
    req_vec   = pv;
  endtask

  task automatic new_op(input int i);
    pa[i] = {$urandom, $urandom, $urandom, $urandom};
    pb[i] = ($urandom_range(0, 7) == 0) ? pa[i] : {$urandom, $urandom, $urandom, $urandom};
    pc[i] = 3'($urandom_range(0, 7));
    pv[i] = 1'($urandom_range(0, 1));
  endtask

  // One clock: check outputs against the model, then advance the model past the edge.
  task automatic tick(output int g);
    logic [1:0] exp_ready;
    logic       exp_rv;
    item_t      it;
    #1;
    g = -1;
    if (q.size() < 2 || rsp_ready)
      for (int k = 1; k <= 2; k++) begin
        int idx;
        idx = (last_g + k) % 2;
        if (g < 0 && req_valid[idx]) g = idx;
      end
    exp_ready = 2'b00;
    if (g >= 0) exp_ready[g] = 1'b1;
    chk("req_ready", 128'(req_ready), 128'(exp_ready));
    exp_rv = (q.size() > 0) && (q[0].age >= 1);
    chk("rsp_valid", 128'(rsp_valid), 128'(exp_rv));
    if (exp_rv) begin
      chk("rsp_id", 128'(rsp_id), 128'(q[0].id));
      chk("rsp_result", rsp_result, q[0].res);
      chk("rsp_zero", 128'(rsp_zero), 128'(q[0].z));
    end
    chk("op_count", 128'(op_count), 128'(cnt_m));
    if (alu_vec === 1'b0) chk("alu_a_upper", 128'(alu_a[127:32]), 128'd0);
    if (exp_rv && rsp_ready) begin
      void'(q.pop_front());
      n_rsp++;
    end
    foreach (q[j]) q[j].age++;
    if (g >= 0) begin
      it.res = model_result(pc[g], pa[g], pb[g], pv[g]);
      it.z   = (it.res == 128'd0);
      it.id  = g;
      it.age = 0;
      q.push_back(it);
      last_g = g;
      cnt_m  = cnt_m + 32'd1;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    last_g = 1;
    cnt_m  = 32'd0;
  endtask

  task automatic run_single(input int i, input logic [127:0] a, input logic [127:0] b, input logic [2:0] c,
                            input logic v, input logic [127:0] er, input logic ez, input string tag);
    int g;
    pend = 2'b00; rsp_ready = 1'b1; drive();
    repeat (3) tick(g);
    pa[i] = a; pb[i] = b; pc[i] = c; pv[i] = v; pend[i] = 1'b1; drive();
    tick(g);
    pend = 2'b00; drive();
    tick(g);
    #1;
    chk({tag, "_valid"}, 128'(rsp_valid), 128'd1);
    chk({tag, "_result"}, rsp_result, er);
    chk({tag, "_zero"}, 128'(rsp_zero), 128'(ez));
    chk({tag, "_id"}, 128'(rsp_id), 128'(i));
    tick(g);
  endtask

  initial begin
    int g, base, acc;
    rst = 1'b1; rsp_ready = 1'b0; pend = 2'b00; pv = 2'b00;
    checks = 0; passes = 0; fails = 0; n_rsp = 0;
    for (int i = 0; i < 2; i++) begin pa[i] = '0; pb[i] = '0; pc[i] = 3'd0; end
    drive();
    @(negedge clk);
    do_reset();
    #1;
    chk("reset_rsp_valid", 128'(rsp_valid), 128'd0);
    chk("reset_op_count", 128'(op_count), 128'd0);
    chk("reset_rsp_result", rsp_result, 128'd0);
    chk("reset_alu_a", alu_a, 128'd0);
    chk("reset_req_ready", 128'(req_ready), 128'd0);

    run_single(0, 128'hA, 128'h14, 3'b000, 1'b0, 128'h1E, 1'b0, "t1_add");

    // Both requesters valid every cycle: grants alternate, one op per cycle.
    rsp_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      for (int i = 0; i < 2; i++) if (!pend[i]) begin new_op(i); pend[i] = 1'b1; end
      drive();
      tick(g);
      if (g >= 0) pend[g] = 1'b0;
    end

    // Six-op stream from requester 0 with a three-cycle response stall.
    pend = 2'b00; drive(); repeat (3) tick(g);
    base = n_rsp; acc = 0;
    for (int c = 0; c < 30; c++) begin
      if (acc < 6 && !pend[0]) begin new_op(0); pend[0] = 1'b1; end
      rsp_ready = !(c >= 2 && c <= 4);
      drive();
      tick(g);
      if (g == 0) begin pend[0] = 1'b0; acc++; end
    end
    chk("t3_rsp_count", 128'(n_rsp - base), 128'd6);

    run_single(1, {32'd8, 32'd7, 32'd6, 32'd5}, {32'd4, 32'd3, 32'd2, 32'd1}, 3'b001, 1'b1,
               {4{32'h00000004}}, 1'b0, "t4_vsub");
    run_single(0, {4{32'h12345678}}, {4{32'h12345678}}, 3'b001, 1'b1, 128'd0, 1'b1, "t4_vzero");
    run_single(1, {{3{32'hFFFFFFFF}}, 32'h80000000}, 128'd2, 3'b111, 1'b0, 128'hE0000000, 1'b0, "t5_sra");

    // Fill both stages, then reset mid-flight.
    rsp_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin new_op(i); pend[i] = 1'b1; end
    drive();
    for (int c = 0; c < 4; c++) begin
      tick(g);
      if (g >= 0) begin pend[g] = 1'b0; new_op(g); pend[g] = 1'b1; drive(); end
    end
    do_reset();
    #1;
    chk("t6_rsp_valid", 128'(rsp_valid), 128'd0);
    chk("t6_op_count", 128'(op_count), 128'd0);
    chk("t6_grant", 128'(req_ready), 128'b01);
    tick(g);
    if (g >= 0) pend[g] = 1'b0;

    // Random traffic with random response backpressure.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 2; i++)
        if (!pend[i] && $urandom_range(0, 99) < 60) begin new_op(i); pend[i] = 1'b1; end
      rsp_ready = ($urandom_range(0, 99) < 70);
      drive();
      tick(g);
      if (g >= 0) pend[g] = 1'b0;
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
